// File: rtl/ahb_wrapper.sv
// ---------------------------------------------------------------------------
// ahb_wrapper
//   AHB-Lite zero-wait-state slave fronting two back ends: a byte-lane
//   register file and an 8-in / 8-out GPIO port. The sideband enables pick
//   the target at address-phase time; the register file wins when both are
//   set. Read data and HRESP are produced combinationally in the data phase
//   from the address-phase registers; writes commit on the edge that ends
//   the data phase, so a read in the following data phase sees the new data.
//
// Ports
//   HCLK             in   bus clock, rising edge
//   HRESETn          in   synchronous reset, active HIGH despite its name
//   HADDR/HWRITE/HTRANS/HBURST/HSIZE  in  address-phase controls
//   HWDATA           in   write data (data phase)
//   GPIO_in          in   GPIO input pins, read at HADDR[7:0] = 8'hFF
//   Register_File_En in   selects the register file (priority)
//   GPIO_En          in   selects GPIO when the register file is not selected
//   HREADY           out  constant 1
//   HRESP            out  1 = ERROR for the current data phase
//   HRDATA           out  read data for the current data phase
//   GPIO_out         out  registered GPIO outputs, written at HADDR[15:8] = 8'h8F
// ---------------------------------------------------------------------------
module ahb_wrapper #(
    parameter int REG_WIDTH  = 8,
    parameter int REG_DEPTH  = 32,
    parameter int GPIO_WIDTH = 16
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic [31:0]             HADDR,
    input  logic                    HWRITE,
    input  logic [1:0]              HTRANS,
    input  logic [2:0]              HBURST,
    input  logic [1:0]              HSIZE,
    input  logic [31:0]             HWDATA,
    input  logic [GPIO_WIDTH/2-1:0] GPIO_in,
    input  logic                    Register_File_En,
    input  logic                    GPIO_En,
    output logic                    HREADY,
    output logic                    HRESP,
    output logic [31:0]             HRDATA,
    output logic [GPIO_WIDTH/2-1:0] GPIO_out
);

    localparam int IDX_W = $clog2(REG_DEPTH);
    localparam int GW    = GPIO_WIDTH / 2;
    localparam int LANES = 32 / REG_WIDTH;

    // Number of byte lanes touched by a given HSIZE.
    function automatic int n_lanes(input logic [1:0] size);
        case (size)
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    // Register-file error: reserved size, misalignment, or write data that
    // does not fit in the transfer size.
    function automatic logic rf_err(input logic [1:0]  size,
                                    input logic [1:0]  a,
                                    input logic        wr,
                                    input logic [31:0] wd);
        case (size)
            2'd0:    return wr && (wd[31:8] != 24'd0);
            2'd1:    return a[0] || (wr && (wd[31:16] != 16'd0));
            2'd2:    return a != 2'd0;
            default: return 1'b1;
        endcase
    endfunction

    // Address-phase registers
    logic                 r_dvld;
    logic [15:0]          r_addr;
    logic                 r_write;
    logic [1:0]           r_size;
    logic                 r_sel_rf;
    logic                 r_sel_gp;

    logic [REG_WIDTH-1:0] r_mem [REG_DEPTH];
    logic [GW-1:0]        r_gpio_out;

    logic                 w_rf_xfer;
    logic                 w_gp_xfer;
    logic                 w_rf_err;
    logic                 w_gp_err;
    logic [31:0]          w_rdata;
    logic                 w_unused_ok;

    // Only the low 16 address bits select anything; bursts need no decode.
    assign w_unused_ok = ^{HADDR[31:16], HBURST};

    always_ff @(posedge HCLK) begin
        if (HRESETn) begin
            r_dvld   <= 1'b0;
            r_addr   <= '0;
            r_write  <= 1'b0;
            r_size   <= '0;
            r_sel_rf <= 1'b0;
            r_sel_gp <= 1'b0;
        end else begin
            // NONSEQ/SEQ both have HTRANS[1] set; IDLE/BUSY open no data phase.
            r_dvld <= HTRANS[1];
            if (HTRANS[1]) begin
                r_addr   <= HADDR[15:0];
                r_write  <= HWRITE;
                r_size   <= HSIZE;
                r_sel_rf <= Register_File_En;
                r_sel_gp <= GPIO_En && !Register_File_En;
            end
        end
    end

    // Data phase: decode and error detection
    assign w_rf_xfer = r_dvld && r_sel_rf;
    assign w_gp_xfer = r_dvld && r_sel_gp;
    assign w_rf_err  = w_rf_xfer && rf_err(r_size, r_addr[1:0], r_write, HWDATA);
    assign w_gp_err  = w_gp_xfer && (r_write ? (r_addr[15:8] != 8'h8F)
                                             : (r_addr[7:0]  != 8'hFF));

    always_comb begin
        w_rdata = '0;
        if (!HRESETn && r_dvld && !r_write) begin
            if (w_rf_xfer && !w_rf_err) begin
                for (int k = 0; k < LANES; k++) begin
                    if (k < n_lanes(r_size))
                        w_rdata[REG_WIDTH*k +: REG_WIDTH] =
                            r_mem[r_addr[IDX_W-1:0] + IDX_W'(k)];
                end
            end else if (w_gp_xfer && !w_gp_err) begin
                w_rdata = {{(32-GW){1'b0}}, GPIO_in};
            end
        end
    end

    // Commit at the end of the data phase; reset discards a pending write.
    always_ff @(posedge HCLK) begin
        if (HRESETn) begin
            for (int i = 0; i < REG_DEPTH; i++)
                r_mem[i] <= '0;
            r_gpio_out <= '0;
        end else begin
            if (w_rf_xfer && r_write && !w_rf_err) begin
                for (int k = 0; k < LANES; k++) begin
                    if (k < n_lanes(r_size))
                        r_mem[r_addr[IDX_W-1:0] + IDX_W'(k)] <=
                            HWDATA[REG_WIDTH*k +: REG_WIDTH];
                end
            end
            if (w_gp_xfer && r_write && !w_gp_err)
                r_gpio_out <= HWDATA[GW-1:0];
        end
    end

    assign HREADY   = 1'b1;
    assign HRESP    = !HRESETn && (w_rf_err || w_gp_err);
    assign HRDATA   = w_rdata;
    assign GPIO_out = r_gpio_out;

endmodule

// File: tb/tb_ahb_wrapper.sv
module tb_ahb_wrapper;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b1;
    logic [31:0] HADDR = '0;
    logic        HWRITE = 1'b0;
    logic [1:0]  HTRANS = 2'b00;
    logic [2:0]  HBURST = 3'b000;
    logic [1:0]  HSIZE = 2'b00;
    logic [31:0] HWDATA = '0;
    logic [7:0]  GPIO_in = '0;
    logic        Register_File_En = 1'b0;
    logic        GPIO_En = 1'b0;
    logic        HREADY;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic [7:0]  GPIO_out;

    ahb_wrapper #(.REG_WIDTH(8), .REG_DEPTH(32), .GPIO_WIDTH(16)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HWRITE(HWRITE),
        .HTRANS(HTRANS), .HBURST(HBURST), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .GPIO_in(GPIO_in), .Register_File_En(Register_File_En), .GPIO_En(GPIO_En),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA), .GPIO_out(GPIO_out)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        string       nm;
        logic        resp;
        logic        chkd;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    logic mon_pend = 1'b0;

    localparam logic [1:0] BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2;
    localparam logic [1:0] NSEQ = 2'b10, SEQ = 2'b11;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Address phase now, data phase on the next cycle; expectation queued here.
    task automatic xfer(input string nm, input logic [1:0] trans, input logic wr,
                        input logic [31:0] addr, input logic [1:0] size,
                        input logic [31:0] wd, input logic eresp,
                        input logic chkd, input logic [31:0] erd);
        exp_t e;
        HTRANS = trans; HWRITE = wr; HADDR = addr; HSIZE = size;
        e.nm = nm; e.resp = eresp; e.chkd = chkd; e.data = erd;
        sb.push_back(e);
        @(posedge HCLK); #1;
        HWDATA = wd;
        HTRANS = 2'b00;
    endtask

    task automatic wr(input string nm, input logic [1:0] trans, input logic [31:0] addr,
                      input logic [1:0] size, input logic [31:0] wd, input logic eresp);
        xfer(nm, trans, 1'b1, addr, size, wd, eresp, 1'b0, 32'h0);
    endtask

    task automatic rd(input string nm, input logic [1:0] trans, input logic [31:0] addr,
                      input logic [1:0] size, input logic eresp, input logic [31:0] erd);
        xfer(nm, trans, 1'b0, addr, size, 32'h0, eresp, 1'b1, erd);
    endtask

    task automatic idle();
        @(posedge HCLK); #1;
    endtask

    // Monitor: a data phase follows every accepted address phase.
    always @(posedge HCLK)
        mon_pend <= (HTRANS[1] === 1'b1) && !HRESETn;

    always @(negedge HCLK) begin
        if (mon_pend) begin
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL scoreboard_underflow: got data phase expected none");
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk({e.nm, "_hready"}, {31'd0, HREADY}, 32'd1);
                chk({e.nm, "_hresp"}, {31'd0, HRESP}, {31'd0, e.resp});
                if (e.chkd) chk({e.nm, "_hrdata"}, HRDATA, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        @(posedge HCLK); @(posedge HCLK); #1;
        chk("rst_hready", {31'd0, HREADY}, 32'd1);
        chk("rst_hresp", {31'd0, HRESP}, 32'd0);
        chk("rst_hrdata", HRDATA, 32'd0);
        chk("rst_gpio_out", {24'd0, GPIO_out}, 32'd0);
        HRESETn = 1'b0;
        idle();

        // Register file basics, read-after-write back to back
        Register_File_En = 1'b1;
        wr("rf_w0", NSEQ, 32'h0002_0000, WORD, 32'h0000_000A, 1'b0);
        rd("rf_r0", NSEQ, 32'h0002_0000, WORD, 1'b0, 32'h0000_000A);
        wr("rf_oversize", NSEQ, 32'h0002_0004, BYTE, 32'h0000_FFFA, 1'b1);
        rd("rf_r4", NSEQ, 32'h0002_0004, WORD, 1'b0, 32'h0);
        idle();

        // INCR4 burst write then read
        HBURST = 3'b011;
        wr("b_w0", NSEQ, 32'h0002_0008, WORD, 32'h0000_000C, 1'b0);
        wr("b_w1", SEQ,  32'h0002_000C, WORD, 32'h0000_0070, 1'b0);
        wr("b_w2", SEQ,  32'h0002_0010, WORD, 32'h0000_00D4, 1'b0);
        wr("b_w3", SEQ,  32'h0002_0014, WORD, 32'h0000_0138, 1'b0);
        rd("b_r0", NSEQ, 32'h0002_0008, WORD, 1'b0, 32'h0000_000C);
        rd("b_r1", SEQ,  32'h0002_000C, WORD, 1'b0, 32'h0000_0070);
        rd("b_r2", SEQ,  32'h0002_0010, WORD, 1'b0, 32'h0000_00D4);
        rd("b_r3", SEQ,  32'h0002_0014, WORD, 1'b0, 32'h0000_0138);
        HBURST = 3'b000;

        // BUSY opens no data phase
        HTRANS = 2'b01; HWRITE = 1'b1; HADDR = 32'h0002_0000; HSIZE = WORD;
        @(posedge HCLK); #1; HTRANS = 2'b00; HWDATA = 32'hFFFF_FFFF;
        idle();

        // Size / alignment errors and sub-word lanes
        wr("rf_size3", NSEQ, 32'h0002_0018, 2'd3, 32'h0000_0001, 1'b1);
        rd("rf_mis_half", NSEQ, 32'h0002_0001, HALF, 1'b1, 32'h0);
        wr("rf_half_w", NSEQ, 32'h0002_0002, HALF, 32'h0000_1234, 1'b0);
        wr("rf_mis_word", NSEQ, 32'h0002_0002, WORD, 32'h0000_5555, 1'b1);
        rd("rf_byte_r", NSEQ, 32'h0002_0003, BYTE, 1'b0, 32'h0000_0012);
        rd("rf_word_r", NSEQ, 32'h0002_0000, WORD, 1'b0, 32'h1234_000A);
        rd("rf_half_r", NSEQ, 32'h0002_0002, HALF, 1'b0, 32'h0000_1234);
        rd("rf_size3_r", NSEQ, 32'h0002_0018, WORD, 1'b0, 32'h0);
        idle();

        // GPIO output
        Register_File_En = 1'b0; GPIO_En = 1'b1;
        wr("gp_w_ok", NSEQ, 32'h0000_8F00, BYTE, 32'h0000_008A, 1'b0);
        idle();
        chk("gp_out_set", {24'd0, GPIO_out}, 32'h0000_008A);
        wr("gp_w_bad", NSEQ, 32'h0000_0025, BYTE, 32'h0000_0011, 1'b1);
        idle();
        chk("gp_out_keep", {24'd0, GPIO_out}, 32'h0000_008A);

        // GPIO input
        GPIO_in = 8'hF4;
        rd("gp_r_ok", NSEQ, 32'h0000_00FF, WORD, 1'b0, 32'h0000_00F4);
        rd("gp_r_bad", NSEQ, 32'h0000_5600, WORD, 1'b1, 32'h0);
        idle();

        // Neither target selected
        GPIO_En = 1'b0;
        rd("none_r", NSEQ, 32'h0000_00FF, WORD, 1'b0, 32'h0);
        wr("none_w", NSEQ, 32'h0000_8F00, BYTE, 32'h0000_0055, 1'b0);
        idle();
        chk("none_gp_keep", {24'd0, GPIO_out}, 32'h0000_008A);

        // Both selected: register file has priority
        Register_File_En = 1'b1; GPIO_En = 1'b1;
        rd("prio_r", NSEQ, 32'h0002_0000, WORD, 1'b0, 32'h1234_000A);
        idle();

        // Reset during a write data phase that would otherwise error
        GPIO_En = 1'b0;
        wr("rst_mid_w", NSEQ, 32'h0002_0000, BYTE, 32'h0000_FFFF, 1'b0);
        HRESETn = 1'b1;
        idle();
        HRESETn = 1'b0;
        chk("rst_mid_gpio", {24'd0, GPIO_out}, 32'd0);
        rd("rst_mid_r0", NSEQ, 32'h0002_0000, WORD, 1'b0, 32'h0);
        rd("rst_mid_r8", NSEQ, 32'h0002_0008, WORD, 1'b0, 32'h0);
        idle();
        idle();

        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
